fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 76 +++++++
 tb/tb_fetch_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch queue: four-entry circular buffer of {PC, instruction} pairs that
// decouples the fetch stage from decode. Flush discards all queued entries on
// a taken branch or jump.
//
// Handshake: a transfer happens on a rising clk edge only when the sender's
// valid and the receiver's ready are both high in the cycle before that edge.
// Once valid is raised, the sender keeps it high and holds the payload steady
// until the transfer happens. in_ready depends only on registered state.
// out_valid depends on registered state and flush.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_PC,
  input  logic [31:0] in_instruct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_PC,
  output logic [31:0] out_instruct,
  output logic [2:0]  count
);

  logic [31:0] mem_pc   [0:3];
  logic [31:0] mem_inst [0:3];
  logic [1:0]  head;
  logic [1:0]  tail;
  logic        push;
  logic        pop;

  // Full and empty come straight from the registered count.
  // Decode never sees an entry while a flush is in progress.
  assign in_ready  = (count != 3'(DEPTH));
  assign out_valid = (count != 3'd0) && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // When the queue is empty, show the reset PC and a zero word.
  // Entries left behind after a flush therefore never reach the outputs.
  assign out_PC       = (count != 3'd0) ? mem_pc[head]   : RESET_PC;
  assign out_instruct = (count != 3'd0) ? mem_inst[head] : 32'h0000_0000;

  // Entry storage. It has no reset and is not cleared by flush; count decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]   <= in_PC;
      mem_inst[tail] <= in_instruct;
    end
  end

  // Update the pointers and the count. Reset clears them immediately; flush clears them on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
    end else if (flush) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) tail <= tail + 2'd1;
      if (pop)  head <= head + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. The driver pushes each expected {PC, instr}
// pair into a queue when the hand-derived result is an accepted push. A
// monitor pops from that queue and compares on every output transfer.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_PC;
  logic [31:0] in_instruct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_PC;
  logic [31:0] out_instruct;
  logic [2:0]  count;

  logic [63:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_PC        (in_PC),
    .in_instruct  (in_instruct),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_PC       (out_PC),
    .out_instruct (out_instruct),
    .count        (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got pc %h with no expected entry", out_PC);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_PC, out_instruct} !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %h/%h expected %h/%h", out_PC, out_instruct, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    in_valid    = v;
    in_PC       = pc;
    in_instruct = ins;
    out_ready   = rdy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({pc, ins});
    step(1'b1, pc, ins, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_PC = 32'h0; in_instruct = 32'h0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_PC, 32'h0000_3000);
    check("rst_out_inst", out_instruct, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Push three entries on three edges while decode does not accept (out_ready = 0).
    push_exp(32'h3000, 32'h3C010001);
    push_exp(32'h3004, 32'h34210002);
    push_exp(32'h3008, 32'h00000000);
    check("three_count", 32'(count), 32'd3);
    check("three_pc", out_PC, 32'h3000);
    check("three_inst", out_instruct, 32'h3C010001);

    // Fill to four entries; offer a fifth while full.
    push_exp(32'h300C, 32'h11111111);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h3010, 32'hDEADBEEF, 1'b0, 1'b0);
    check("full_ignore_count", 32'(count), 32'd4);
    // While full, a pop does not let the offered push in during the same cycle.
    step(1'b1, 32'h3010, 32'hDEADBEEF, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_pc", out_PC, 32'h3000);
    check("drain_inst", out_instruct, 32'h0);

    // Start at count 2, then push and pop together for six cycles; the pointers wrap.
    push_exp(32'h3100, 32'hA0000000);
    push_exp(32'h3104, 32'hA0000001);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({32'h3108 + 32'(i * 4), 32'hB0000000 + 32'(i)});
      step(1'b1, 32'h3108 + 32'(i * 4), 32'hB0000000 + 32'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count), 32'd2);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stream_drained", 32'(count), 32'd0);

    // Flush at count 3 while 0x3020 is offered.
    push_exp(32'h3200, 32'hC0000000);
    push_exp(32'h3204, 32'hC0000001);
    push_exp(32'h3208, 32'hC0000002);
    in_valid = 1'b1; in_PC = 32'h3020; in_instruct = 32'hC0DE0000;
    out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    exp_q.delete();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_pc", out_PC, 32'h3000);
    push_exp(32'h3300, 32'hD0000000);
    check("post_flush_pc", out_PC, 32'h3300);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Assert reset between clock edges while count is 2.
    push_exp(32'h3400, 32'hE0000000);
    push_exp(32'h3404, 32'hE0000001);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_pc", out_PC, 32'h3000);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    // Push on the first edge after reset is released.
    push_exp(32'h3500, 32'hF0000000);
    check("post_rst_count", 32'(count), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty queue: hold out_ready high for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("empty_count", 32'(count), 32'd0);
      check("empty_pc", out_PC, 32'h3000);
      check("empty_inst", out_instruct, 32'h0);
    end

    idle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
